// File: rtl/gf_minus1_pkg.sv
// Shared audio-path definitions: sample format, silence level and feeder state encoding.
// Also used by interpolator_1000x, so keep it free of feeder-only details.
package gf_minus1;

    localparam int SAMPLE_W   = 8;
    localparam int UNDERRUN_W = 16;

    typedef logic [SAMPLE_W-1:0]   sample_t;
    typedef logic [UNDERRUN_W-1:0] underrun_t;

    // Offset-binary midpoint: the value that produces no output swing.
    localparam sample_t MIDSCALE_DEFAULT = 8'h80;

    typedef enum logic [1:0] {
        ST_PREFILL = 2'd0,
        ST_RUN     = 2'd1,
        ST_STARVED = 2'd2
    } feeder_state_e;

    function automatic underrun_t sat_inc(input underrun_t value);
        return (value == '1) ? value : value + underrun_t'(1);
    endfunction

endpackage : gf_minus1

// File: rtl/sample_feeder_48k_fifo.sv
// Synchronous FIFO with occupancy output and registered full/empty flags.
// Depth must be a power of two so the pointers wrap on their own.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    // Flush wins over both ports; over/underflow requests are dropped.
    assign do_push = push && !full_q  && !flush;
    assign do_pop  = pop  && !empty_q && !flush;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == LW'(DEPTH));
            empty_q  <= (level_d == '0);
        end
    end

    // NOTE: the storage array has no reset; pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q];
    assign level   = level_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule : sync_fifo

// File: rtl/sample_feeder_48k.sv
// Buffers upstream audio samples and releases one per 48 kHz strobe as a (previous, current)
// pair for the interpolator, with prefill/starvation handling and an underrun counter.
module sample_feeder_48k
    import gf_minus1::*;
#(
    parameter int      DEPTH    = 16,
    parameter int      PREFILL  = 8,
    parameter sample_t MIDSCALE = MIDSCALE_DEFAULT,
    localparam int     LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pulse_48k,
    input  logic                  flush,
    input  logic                  s_valid,
    input  logic [SAMPLE_W-1:0]   s_data,
    output logic                  s_ready,
    output logic [SAMPLE_W-1:0]   signal_x0,
    output logic [SAMPLE_W-1:0]   signal_x1,
    output logic [LVL_W-1:0]      level,
    output logic                  playing,
    output logic [UNDERRUN_W-1:0] underrun_count
);

    localparam logic [LVL_W-1:0] PREFILL_LVL = LVL_W'(PREFILL);

    feeder_state_e state_q;
    sample_t       x0_q, x1_q;
    logic          playing_q;
    underrun_t     underrun_q;
    logic          ready_en_q;

    logic          fifo_full, fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    sample_t       fifo_head;
    logic          push, take, starve;

    // Ready comes only from registers, so upstream never sees a path from pulse or valid.
    assign s_ready = ready_en_q && !fifo_full;
    assign push    = s_valid && s_ready;

    // Decisions use the pre-edge level, so a same-cycle push cannot satisfy this pulse.
    always_comb begin
        take   = 1'b0;
        starve = 1'b0;
        if (pulse_48k && !flush) begin
            unique case (state_q)
                ST_RUN: begin
                    take   = !fifo_empty;
                    starve = fifo_empty;
                end
                ST_STARVED: begin
                    take   = (fifo_level >= PREFILL_LVL);
                    starve = !take;
                end
                default: take = (fifo_level >= PREFILL_LVL);
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .pop     (take),
        .wr_data (s_data),
        .rd_data (fifo_head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_PREFILL;
            x0_q       <= MIDSCALE;
            x1_q       <= MIDSCALE;
            playing_q  <= 1'b0;
            underrun_q <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (flush) begin
                state_q   <= ST_PREFILL;
                x0_q      <= MIDSCALE;
                x1_q      <= MIDSCALE;
                playing_q <= 1'b0;
            end else if (take) begin
                state_q   <= ST_RUN;
                x0_q      <= x1_q;
                x1_q      <= fifo_head;
                playing_q <= 1'b1;
            end else if (starve) begin
                // Repeat the last sample so the interpolator ramps to a flat line.
                state_q    <= ST_STARVED;
                x0_q       <= x1_q;
                playing_q  <= 1'b0;
                underrun_q <= sat_inc(underrun_q);
            end
        end
    end

    assign signal_x0      = x0_q;
    assign signal_x1      = x1_q;
    assign level          = fifo_level;
    assign playing        = playing_q;
    assign underrun_count = underrun_q;

endmodule : sample_feeder_48k
